// File: rtl/perceptron_mac.sv
// Perceptron compute engine: streams N_INPUTS input/weight pairs from the register
// banks, accumulates the signed products plus bias, and applies a step activation.
module perceptron_mac #(
    parameter int unsigned N_INPUTS = 8,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ACC_W    = 20,
    parameter int unsigned ADDR_W   = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic signed [DATA_W-1:0] bias,
    output logic                     rd_en,
    output logic        [ADDR_W-1:0] rd_addr,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic signed [DATA_W-1:0] w_data,
    output logic                     busy,
    output logic                     done,
    output logic signed [ACC_W-1:0]  acc_out,
    output logic                     y
);

    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_INPUTS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        ACT   = 2'd3
    } state_t;

    state_t                    state_q;
    logic signed [DATA_W-1:0]  bias_q;
    logic signed [ACC_W-1:0]   acc_q;
    logic                      data_vld_q;
    logic                      rd_en_q;
    logic        [ADDR_W-1:0]  rd_addr_q;
    logic                      busy_q;
    logic                      done_q;
    logic signed [ACC_W-1:0]   acc_out_q;
    logic                      y_q;

    logic signed [PROD_W-1:0]  prod_c;
    logic signed [ACC_W-1:0]   acc_d;
    logic signed [ACC_W-1:0]   sum_d;

    // Bank data arrives one cycle after each read strobe; fold it in on that edge.
    always_comb begin
        prod_c = in_data * w_data;
        acc_d  = acc_q;
        if (data_vld_q) begin
            acc_d = acc_q + ACC_W'(prod_c);
        end
        sum_d = acc_d + ACC_W'(bias_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            bias_q     <= '0;
            acc_q      <= '0;
            data_vld_q <= 1'b0;
            rd_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            acc_out_q  <= '0;
            y_q        <= 1'b0;
        end else begin
            data_vld_q <= rd_en_q;
            done_q     <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        bias_q    <= bias;
                        acc_q     <= '0;
                        rd_en_q   <= 1'b1;
                        rd_addr_q <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= READ;
                    end
                end
                READ: begin
                    acc_q <= acc_d;
                    if (rd_addr_q == LAST_ADDR) begin
                        rd_en_q <= 1'b0;
                        state_q <= DRAIN;
                    end else begin
                        rd_addr_q <= rd_addr_q + ADDR_W'(1);
                    end
                end
                // Final product lands here; result and done go out together.
                DRAIN: begin
                    acc_q     <= acc_d;
                    acc_out_q <= sum_d;
                    y_q       <= ~sum_d[ACC_W-1];
                    done_q    <= 1'b1;
                    state_q   <= ACT;
                end
                ACT: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rd_en   = rd_en_q;
    assign rd_addr = rd_addr_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign acc_out = acc_out_q;
    assign y       = y_q;

endmodule
